// File: rtl/register_file_16x32.sv
// 16 x DW architectural register file; R15 doubles as the program counter with its own
// load/increment path. All registers are exported flat for external operand muxes.
module register_file_16x32 #(
  parameter int unsigned    DW       = 32,
  parameter logic [DW-1:0]  RESET_PC = '0,
  parameter int unsigned    PC_STEP  = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          RF_WE,
  input  logic [3:0]    WA,
  input  logic [DW-1:0] WD,
  input  logic          PC_Ld,
  input  logic [DW-1:0] PC_D,
  input  logic          PC_Inc,
  input  logic [3:0]    RA_Sel,
  input  logic [3:0]    RB_Sel,
  input  logic [3:0]    RD_Sel,
  output logic [DW-1:0] QA,
  output logic [DW-1:0] QB,
  output logic [DW-1:0] QD,
  output logic [DW-1:0] PC_Q,
  output logic [DW-1:0] R0_Q,
  output logic [DW-1:0] R1_Q,
  output logic [DW-1:0] R2_Q,
  output logic [DW-1:0] R3_Q,
  output logic [DW-1:0] R4_Q,
  output logic [DW-1:0] R5_Q,
  output logic [DW-1:0] R6_Q,
  output logic [DW-1:0] R7_Q,
  output logic [DW-1:0] R8_Q,
  output logic [DW-1:0] R9_Q,
  output logic [DW-1:0] R10_Q,
  output logic [DW-1:0] R11_Q,
  output logic [DW-1:0] R12_Q,
  output logic [DW-1:0] R13_Q,
  output logic [DW-1:0] R14_Q,
  output logic [DW-1:0] R15_Q
);

  logic [DW-1:0] regs_q [16];
  logic [15:0]   we_dec;
  logic [DW-1:0] pc_d;

  // One-hot write enables, one per register.
  always_comb begin
    we_dec = '0;
    if (RF_WE) we_dec = 16'b1 << WA;
  end

  // R15 next state: general write beats load, load beats increment.
  always_comb begin
    pc_d = regs_q[15];
    if (we_dec[15]) begin
      pc_d = WD;
    end else if (PC_Ld) begin
      pc_d = PC_D;
    end else if (PC_Inc) begin
      pc_d = regs_q[15] + DW'(PC_STEP);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      regs_q[15] <= RESET_PC;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (we_dec[i]) regs_q[i] <= WD;
      end
      regs_q[15] <= pc_d;
    end
  end

  assign QA   = regs_q[RA_Sel];
  assign QB   = regs_q[RB_Sel];
  assign QD   = regs_q[RD_Sel];
  assign PC_Q = regs_q[15];

  assign R0_Q  = regs_q[0];
  assign R1_Q  = regs_q[1];
  assign R2_Q  = regs_q[2];
  assign R3_Q  = regs_q[3];
  assign R4_Q  = regs_q[4];
  assign R5_Q  = regs_q[5];
  assign R6_Q  = regs_q[6];
  assign R7_Q  = regs_q[7];
  assign R8_Q  = regs_q[8];
  assign R9_Q  = regs_q[9];
  assign R10_Q = regs_q[10];
  assign R11_Q = regs_q[11];
  assign R12_Q = regs_q[12];
  assign R13_Q = regs_q[13];
  assign R14_Q = regs_q[14];
  assign R15_Q = regs_q[15];

endmodule

// File: doc/register_file_16x32.md
Name: register_file_16x32

Overview:
- 16 x 32-bit architectural register file (R0-R15) for the datapath. Sits directly upstream of the 16:1 32-bit operand selectors.
- Exposes all 16 register values as flat outputs, so three operand selectors (A, B, store-data) can be built from existing 16:1 mux instances. Also provides three local read ports.
- R15 is the program counter. It has its own load and increment controls alongside the general write port.

Parameters:
- DW, 32, data width of each register
- RESET_PC, 32'h0000_0000, value loaded into R15 on reset
- PC_STEP, 4, increment applied to R15 on PC_Inc

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears state immediately
- RF_WE  input  1  general write enable
- WA  input  4  general write address
- WD  input  DW  general write data
- PC_Ld  input  1  load R15 from PC_D
- PC_D  input  DW  PC load value
- PC_Inc  input  1  R15 <= R15 + PC_STEP
- RA_Sel  input  4  read port A address
- RB_Sel  input  4  read port B address
- RD_Sel  input  4  read port D (store data) address
- QA  output  DW  read port A data
- QB  output  DW  read port B data
- QD  output  DW  read port D data
- PC_Q  output  DW  current R15 value
- R0_Q..R15_Q  output  DW each  raw register contents, for external 16:1 muxes

Behaviour:
- Reset (asynchronous, active-high, level-sensitive):
  - R0-R14 go to 0 and R15 goes to RESET_PC immediately, without waiting for Clk.
  - While Reset is high, all writes, loads and increments are ignored.
  - Deassertion takes effect on the next rising edge; the first write can land on that edge.
- Read ports QA, QB, QD and PC_Q are purely combinational from the current register state. Zero latency.
- No write-through:
  - A read of the address being written returns the old value until the rising edge.
  - After the edge, the new value appears in the same cycle.
- General write: on a rising edge with RF_WE=1, Reg[WA] <= WD. Exactly one register changes per edge; all others hold.
- Decoding must cover all 16 addresses 0000-1111 in natural binary order, with no aliasing.
  - Write address 1011 targets R11 and 1100 targets R12.
  - Verification checks every address individually.
- R15 update priority on a rising edge (highest first):
  1. RF_WE=1 and WA=4'hF: R15 <= WD.
  2. PC_Ld=1: R15 <= PC_D.
  3. PC_Inc=1: R15 <= R15 + PC_STEP, modulo 2^DW (wraps silently; no flag).
  4. Otherwise R15 holds.
- Simultaneous general write to Rn (n<15) and PC_Ld/PC_Inc: both take effect on the same edge.
- RF_WE=0: WA and WD are don't-care. No register changes except through PC_Ld/PC_Inc.
- X or Z on any select input is not permitted. The bench never drives it, and output is undefined if it occurs.
- Structure:
  - Sixteen DW-bit registers with per-register enable from a 4:16 decoder gated by RF_WE.
  - A three-input next-state mux on R15 following the priority above.
  - Three 16:1 read selectors.
- Target size: 150-300 lines.

Test Plan:
1. Reset behaviour:
   - Stimulus: drive Reset=1 mid-cycle with registers holding nonzero data.
   - Required: R0-R14 read 0 and PC_Q reads RESET_PC before the next edge.
   - Required: RF_WE=1 while Reset is high causes no change.
2. Address decoding:
   - Stimulus: write 32'hA5A5_0000+n to every Rn, n=0..14, one per cycle; then read through QA, QB and QD with all three selects swept 0..15.
   - Required: each port returns exactly the value written to that address. Explicitly check 1011 returns R11 and 1100 returns R12.
3. Read during write:
   - Stimulus: RA_Sel=5 with R5=32'h1111_1111; drive RF_WE=1, WA=5, WD=32'h2222_2222.
   - Required: QA=1111_1111 before the edge and 2222_2222 after it.
4. R15 priority:
   - Stimulus: same edge with RF_WE=1, WA=F, WD=32'hDEAD_BEEF, PC_Ld=1, PC_D=32'h100, PC_Inc=1.
   - Required: PC_Q=DEAD_BEEF.
   - Next edge with only PC_Ld=1, PC_D=32'h100 and PC_Inc=1: PC_Q=100.
   - Next edge with only PC_Inc=1: PC_Q=104.
5. PC wrap:
   - Stimulus: PC_Ld with PC_D=32'hFFFF_FFFC, then PC_Inc for one edge.
   - Required: PC_Q=0.
   - Concurrent RF_WE=1, WA=3, WD=7 on the increment edge: R3=7 on the same edge.
6. Asynchronous reset mid-operation:
   - Stimulus: assert Reset between edges during a burst of PC_Inc.
   - Required: PC_Q=RESET_PC immediately.
   - After deassertion, the first PC_Inc edge gives RESET_PC+4.
